// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD asynchronous read ports
// and one synchronous write port. It has an optional hardwired-zero register
// 0 and an optional write-to-read bypass. A sequential clear engine zeroes one
// entry per cycle after reset or on clr_req. A per-register pending-write
// scoreboard feeds the hazard unit.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset (forces CLEAR)
//   clr_req   in   in READY, starts a full array clear
//   ready     out  registered, high when the array is usable
//   wr_en     in   write enable
//   wr_addr   in   write index
//   wr_data   in   write data
//   iss_en    in   issue strobe, marks iss_addr pending
//   iss_addr  in   destination index of the issued instruction
//   rd_addr   in   packed read indices, port p at [p*ADDR_W +: ADDR_W]
//   rd_data   out  packed combinational read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy   out  pending-write flag for each read port
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]     LP_LAST = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0] LP_ONE  = NUM_REGS'(1);
    localparam bit                  LP_ZERO = (ZERO_REG != 0);
    localparam bit                  LP_BYP  = (BYPASS != 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_clr_cnt;
    logic [ADDR_W:0]     w_clr_cnt_nxt;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] w_wr_mask;
    logic [NUM_REGS-1:0] w_iss_mask;
    logic                w_in_ready;
    logic                w_soft_clr;
    logic                w_wr_commit;
    logic                w_iss_set;

    assign w_in_ready = (r_state == S_READY);
    assign w_soft_clr = w_in_ready && clr_req;

    // A clear request on the same edge takes priority and drops the write and the issue.
    assign w_wr_commit = w_in_ready && wr_en && !clr_req && !(LP_ZERO && (wr_addr == '0));
    assign w_iss_set   = w_in_ready && iss_en && !clr_req && !(LP_ZERO && (iss_addr == '0));

    // Next-state and clear-counter logic
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == LP_LAST) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_ready   <= (w_state_nxt == S_READY);
        end
    end

    // The array is not reset. The clear engine owns the write port while in CLEAR.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (w_wr_commit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Clear first and set second, so that a new issue overrides an older writeback to the same index.
    assign w_wr_mask  = w_wr_commit ? (LP_ONE << wr_addr)  : '0;
    assign w_iss_mask = w_iss_set   ? (LP_ONE << iss_addr) : '0;
    assign w_busy_nxt = w_soft_clr ? '0 : ((r_busy & ~w_wr_mask) | w_iss_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign ready = r_ready;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];

        // The bypass only forwards data. Busy keeps the registered value even
        // when a matching write is present, and the hazard unit masks it.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (r_ready) begin
                if (LP_ZERO && (w_ra == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else begin
                    if (LP_BYP && wr_en && (wr_addr == w_ra)) begin
                        w_data = wr_data;
                    end else begin
                        w_data = r_mem[w_ra];
                    end
                    w_busy = r_busy[w_ra];
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_data;
        assign rd_busy[p]                  = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp. It uses three instances:
// the default configuration (a_), BYPASS=0 (b_), and a wide configuration (c_)
// with 64-bit data, 16 registers and 4 read ports. Expected read data goes into
// a queue when the stimulus is driven and is popped when the DUT output is sampled.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_clr_req, a_ready, a_wr_en, a_iss_en;
    logic [4:0]  a_wr_addr, a_iss_addr;
    logic [31:0] a_wr_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;

    logic        b_clr_req, b_ready, b_wr_en, b_iss_en;
    logic [4:0]  b_wr_addr, b_iss_addr;
    logic [31:0] b_wr_data;
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;

    logic         c_clr_req, c_ready, c_wr_en, c_iss_en;
    logic [3:0]   c_wr_addr, c_iss_addr;
    logic [63:0]  c_wr_data;
    logic [15:0]  c_rd_addr;
    logic [255:0] c_rd_data;
    logic [3:0]   c_rd_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q_exp[$];

    regfile_mp u_a (
        .clk(clk), .rst(rst), .clr_req(a_clr_req), .ready(a_ready),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(b_clr_req), .ready(b_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy)
    );

    regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) u_c (
        .clk(clk), .rst(rst), .clr_req(c_clr_req), .ready(c_ready),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] addr, input logic [31:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic write_c(input logic [3:0] addr, input logic [63:0] data);
        c_wr_en = 1'b1; c_wr_addr = addr; c_wr_data = data;
        tick();
        c_wr_en = 1'b0;
    endtask

    task automatic bringup();
        int n;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n = 0;
        while (!(a_ready && b_ready && c_ready) && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if ({a_ready, b_ready, c_ready} !== 3'b111) begin
            n_errors++;
            $display("FAIL bringup_ready got=%b exp=111", {a_ready, b_ready, c_ready});
        end
    endtask

    task automatic test_reset();
        logic [63:0] e0, e1;
        int na, nc;
        for (int i = 1; i < 32; i++) write_a(5'(i), 32'hDEADBEEF);
        a_rd_addr = {5'd30, 5'd31};
        q_exp.push_back(64'hDEADBEEF);
        #1;
        e0 = q_exp.pop_front();
        n_checks++;
        if (a_rd_data[31:0] !== e0[31:0]) begin
            n_errors++; $display("FAIL preload_x31 got=%h exp=%h", a_rd_data[31:0], e0[31:0]);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({a_ready, c_ready} !== 2'b00) begin
            n_errors++; $display("FAIL rst_ready got=%b exp=00", {a_ready, c_ready});
        end
        n_checks++;
        if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL rst_outputs data=%h busy=%b exp=0", a_rd_data, a_rd_busy);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_rd_data !== 64'h0) begin
            n_errors++; $display("FAIL clear_rd_zero got=%h exp=0", a_rd_data);
        end
        na = 0; nc = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (a_ready && na == 0) na = e;
            if (c_ready && nc == 0) nc = e;
            if (na != 0 && nc != 0) break;
        end
        n_checks++;
        if (na !== 32) begin
            n_errors++; $display("FAIL reset_edges_a got=%0d exp=32", na);
        end
        n_checks++;
        if (nc !== 16) begin
            n_errors++; $display("FAIL reset_edges_c got=%0d exp=16", nc);
        end
        for (int i = 0; i < 16; i++) begin
            a_rd_addr = {5'(2*i+1), 5'(2*i)};
            q_exp.push_back(64'h0);
            q_exp.push_back(64'h0);
            #1;
            e0 = q_exp.pop_front();
            e1 = q_exp.pop_front();
            n_checks++;
            if (a_rd_data[31:0] !== e0[31:0]) begin
                n_errors++; $display("FAIL cleared_x%0d got=%h exp=%h", 2*i, a_rd_data[31:0], e0[31:0]);
            end
            n_checks++;
            if (a_rd_data[63:32] !== e1[31:0]) begin
                n_errors++; $display("FAIL cleared_x%0d got=%h exp=%h", 2*i+1, a_rd_data[63:32], e1[31:0]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [63:0] e0, e1;
        write_a(5'd5, 32'h12345678);
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_rd_addr = {5'd0, 5'd5};
        q_exp.push_back(64'h12345678);
        q_exp.push_back(64'h0);
        #1;
        e0 = q_exp.pop_front();
        e1 = q_exp.pop_front();
        n_checks++;
        if (a_rd_data[31:0] !== e0[31:0]) begin
            n_errors++; $display("FAIL wr_rd_x5 got=%h exp=%h", a_rd_data[31:0], e0[31:0]);
        end
        n_checks++;
        if (a_rd_data[63:32] !== e1[31:0]) begin
            n_errors++; $display("FAIL zero_bypass_x0 got=%h exp=%h", a_rd_data[63:32], e1[31:0]);
        end
        tick();
        a_wr_en = 1'b0;
        #1;
        n_checks++;
        if (a_rd_data[63:32] !== 32'h0) begin
            n_errors++; $display("FAIL zero_reg_x0 got=%h exp=0", a_rd_data[63:32]);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e0;
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5A5A5A5;
        a_rd_addr = {5'd0, 5'd7};
        q_exp.push_back(64'hA5A5A5A5);
        #1;
        e0 = q_exp.pop_front();
        n_checks++;
        if (a_rd_data[31:0] !== e0[31:0]) begin
            n_errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", a_rd_data[31:0], e0[31:0]);
        end
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'hA5A5A5A5;
        b_rd_addr = {5'd0, 5'd7};
        q_exp.push_back(64'h0);
        #1;
        e0 = q_exp.pop_front();
        n_checks++;
        if (b_rd_data[31:0] !== e0[31:0]) begin
            n_errors++; $display("FAIL nobypass_old got=%h exp=%h", b_rd_data[31:0], e0[31:0]);
        end
        q_exp.push_back(64'hA5A5A5A5);
        tick();
        b_wr_en = 1'b0;
        e0 = q_exp.pop_front();
        n_checks++;
        if (b_rd_data[31:0] !== e0[31:0]) begin
            n_errors++; $display("FAIL nobypass_next got=%h exp=%h", b_rd_data[31:0], e0[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        a_rd_addr = {5'd0, 5'd3};
        a_iss_en = 1'b1; a_iss_addr = 5'd3;
        #1;
        n_checks++;
        if (a_rd_busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL busy_before_iss got=%b exp=0", a_rd_busy[0]);
        end
        tick();
        a_iss_en = 1'b0;
        n_checks++;
        if (a_rd_busy[0] !== 1'b1) begin
            n_errors++; $display("FAIL busy_after_iss got=%b exp=1", a_rd_busy[0]);
        end
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        #1;
        n_checks++;
        if (a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h33) begin
            n_errors++; $display("FAIL busy_bypass_cycle busy=%b data=%h exp busy=1 data=33", a_rd_busy[0], a_rd_data[31:0]);
        end
        tick();
        a_wr_en = 1'b0;
        n_checks++;
        if (a_rd_busy[0] !== 1'b0) begin
            n_errors++; $display("FAIL busy_after_write got=%b exp=0", a_rd_busy[0]);
        end
        a_iss_en = 1'b1; a_iss_addr = 5'd3;
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h44;
        tick();
        a_iss_en = 1'b0; a_wr_en = 1'b0;
        n_checks++;
        if (a_rd_busy[0] !== 1'b1) begin
            n_errors++; $display("FAIL busy_set_wins got=%b exp=1", a_rd_busy[0]);
        end
        write_a(5'd3, 32'h44);
        a_iss_en = 1'b1; a_iss_addr = 5'd0;
        tick();
        a_iss_en = 1'b0;
        n_checks++;
        if (a_rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL busy_iss_x0 got=%b exp=00", a_rd_busy);
        end
        a_iss_en = 1'b1; a_iss_addr = 5'd6;
        tick();
        a_iss_en = 1'b0;
        a_rd_addr = {5'd6, 5'd6};
        #1;
        n_checks++;
        if (a_rd_busy !== 2'b11) begin
            n_errors++; $display("FAIL busy_shared_addr got=%b exp=11", a_rd_busy);
        end
        write_a(5'd6, 32'h66);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [63:0] e0;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                d = $urandom();
                a_wr_en = 1'b1; a_wr_addr = 5'(10 + k); a_wr_data = d;
                q_exp.push_back({32'h0, d});
            end else begin
                a_wr_en = 1'b0;
            end
            if (k > 0) begin
                a_rd_addr = {5'(10 + k - 1), 5'd0};
                #1;
                e0 = q_exp.pop_front();
                n_checks++;
                if (a_rd_data[63:32] !== e0[31:0]) begin
                    n_errors++; $display("FAIL b2b_x%0d got=%h exp=%h", 10 + k - 1, a_rd_data[63:32], e0[31:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_soft_clear();
        int n;
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        tick();
        a_iss_en = 1'b0;
        a_rd_addr = {5'd5, 5'd9};
        #1;
        n_checks++;
        if (a_rd_busy[0] !== 1'b1 || a_rd_data[63:32] !== 32'h12345678) begin
            n_errors++; $display("FAIL preclr_state busy=%b x5=%h exp busy=1 x5=12345678", a_rd_busy[0], a_rd_data[63:32]);
        end
        a_clr_req = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h11;
        a_iss_en = 1'b1; a_iss_addr = 5'd12;
        tick();
        a_clr_req = 1'b0; a_wr_en = 1'b0; a_iss_en = 1'b0;
        n_checks++;
        if (a_ready !== 1'b0 || a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL clr_outputs ready=%b data=%h busy=%b exp 0", a_ready, a_rd_data, a_rd_busy);
        end
        n = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (a_ready) begin
                n = e;
                break;
            end
        end
        n_checks++;
        if (n !== 32) begin
            n_errors++; $display("FAIL soft_clr_edges got=%0d exp=32 after clr edge", n);
        end
        a_rd_addr = {5'd5, 5'd4};
        #1;
        n_checks++;
        if (a_rd_data !== 64'h0) begin
            n_errors++; $display("FAIL soft_clr_data got=%h exp=0", a_rd_data);
        end
        a_rd_addr = {5'd12, 5'd9};
        #1;
        n_checks++;
        if (a_rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL soft_clr_busy got=%b exp=00", a_rd_busy);
        end
    endtask

    task automatic test_wide();
        logic [63:0] v [4];
        logic [63:0] e0;
        logic [3:0]  idx [4];
        idx[0] = 4'd1; idx[1] = 4'd2; idx[2] = 4'd3; idx[3] = 4'd15;
        v[0] = {$urandom(), $urandom()};
        v[1] = 64'h8000_0000_0000_0001;
        v[2] = {$urandom(), $urandom()};
        v[3] = 64'hFEDC_BA98_7654_3210;
        for (int p = 0; p < 4; p++) begin
            write_c(idx[p], v[p]);
            q_exp.push_back(v[p]);
        end
        c_rd_addr = {idx[3], idx[2], idx[1], idx[0]};
        #1;
        for (int p = 0; p < 4; p++) begin
            e0 = q_exp.pop_front();
            n_checks++;
            if (c_rd_data[p*64 +: 64] !== e0) begin
                n_errors++; $display("FAIL wide_port%0d got=%h exp=%h", p, c_rd_data[p*64 +: 64], e0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_clr_req = 1'b0; a_wr_en = 1'b0; a_iss_en = 1'b0;
        a_wr_addr = '0; a_iss_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_clr_req = 1'b0; b_wr_en = 1'b0; b_iss_en = 1'b0;
        b_wr_addr = '0; b_iss_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        c_clr_req = 1'b0; c_wr_en = 1'b0; c_iss_en = 1'b0;
        c_wr_addr = '0; c_iss_addr = '0; c_wr_data = '0; c_rd_addr = '0;
        bringup();
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_back_to_back();
        test_soft_clear();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
